// File: rtl/serial_sum_unpacker.sv
// Bit-serial recovery of the third addend of a 3-operand add: d = {s_carry, s} - a - b.
// Optional macro SERIAL_SUM_UNPACKER_FASTPATH_EN lets DONE retire and accept on the same edge.
module serial_sum_unpacker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic             s_carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             underflow,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] s_reg, a_reg, b_reg, d_reg;
  logic             carry_reg;
  logic [1:0]       borrow_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             accept, retire;

  logic [2:0] need;
  logic [2:0] borrow_sum;
  logic [1:0] borrow_next;
  logic       d_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        retire = out_ready;
`ifdef SERIAL_SUM_UNPACKER_FASTPATH_EN
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? SHIFT : IDLE;
`else
        if (out_ready) state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
    accept = in_valid & in_ready;
  end

  // t = s - a - b - borrow; with need = a + b + borrow, -floor(t/2) = (need - s + 1) >> 1.
  always_comb begin
    need        = {2'b00, a_reg[0]} + {2'b00, b_reg[0]} + {1'b0, borrow_reg};
    borrow_sum  = need + 3'd1 - {2'b00, s_reg[0]};
    borrow_next = borrow_sum[2:1];
    d_bit       = s_reg[0] ^ need[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg      <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      d_reg      <= '0;
      carry_reg  <= 1'b0;
      borrow_reg <= 2'd0;
      cnt_reg    <= '0;
      out_valid  <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (retire) out_valid <= 1'b0;
      if (accept) begin
        s_reg      <= s;
        a_reg      <= a;
        b_reg      <= b;
        carry_reg  <= s_carry;
        borrow_reg <= 2'd0;
        cnt_reg    <= '0;
      end else if (state_reg == SHIFT) begin
        s_reg      <= s_reg >> 1;
        a_reg      <= a_reg >> 1;
        b_reg      <= b_reg >> 1;
        borrow_reg <= borrow_next;
        d_reg      <= {d_bit, d_reg[WIDTH-1:1]};
        // The final bit also settles the carry-column flags: top = s_carry - borrow.
        if (cnt_reg == LAST) begin
          out_valid <= 1'b1;
          underflow <= ({1'b0, carry_reg} < borrow_next);
          overflow  <= carry_reg & (borrow_next == 2'd0);
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  assign d = d_reg;

endmodule
